// File: rtl/rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin arbiter slice.
package rr_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_e;

  // Bit width able to hold values 0..v-1, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first eligible request at or after
// start, wrapping around, with an optional exclude mask.
module rr_pick #(
  parameter  int unsigned Count      = 4,
  localparam int unsigned IndexWidth = $clog2(Count)
) (
  input  logic [Count-1:0]      request,
  input  logic [IndexWidth-1:0] start,
  input  logic [Count-1:0]      exclude,
  output logic [Count-1:0]      pick,
  output logic [IndexWidth-1:0] index,
  output logic                  any
);

  localparam logic [IndexWidth:0] CountExt = (IndexWidth + 1)'(Count);

  logic [Count-1:0]    eligible;
  logic [2*Count-1:0]  doubled;
  logic [Count-1:0]    rotated;
  logic [IndexWidth:0] offset;
  logic [IndexWidth:0] sum;
  logic                found;

  // Doubling the vector lets a plain right shift act as a rotate, so the
  // search always starts at bit 0 of the rotated view.
  assign eligible = request & ~exclude;
  assign doubled  = {eligible, eligible};
  assign rotated  = Count'(doubled >> start);

  // Priority-find the lowest set bit of the rotated view, then map back.
  always_comb begin
    offset = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < Count; i++) begin
      if (!found && rotated[i]) begin
        offset = (IndexWidth + 1)'(i);
        found  = 1'b1;
      end
    end
    sum = {1'b0, start} + offset;
    if (sum >= CountExt) begin
      sum = sum - CountExt;
    end
    any   = found;
    index = found ? sum[IndexWidth-1:0] : '0;
    pick  = '0;
    for (int unsigned i = 0; i < Count; i++) begin
      pick[i] = found && (index == IndexWidth'(i));
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter producing a registered one-hot select for onehot_mux,
// with grant hold while the owner keeps requesting and a bounded hold time.
module rr_arbiter
  import rr_arbiter_pkg::*;
#(
  parameter  int unsigned Count      = 4,
  parameter  int unsigned MaxHold    = 8,
  localparam int unsigned IndexWidth = $clog2(Count)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [Count-1:0]      request,
  output logic [Count-1:0]      grant,
  output logic                  grant_valid,
  output logic [IndexWidth-1:0] grant_index
);

  localparam int unsigned            HoldWidth = clog2_min1(MaxHold + 1);
  localparam logic [HoldWidth-1:0]   HoldLimit = HoldWidth'(MaxHold);
  localparam logic [IndexWidth-1:0]  LastIndex = IndexWidth'(Count - 1);

  arb_state_e            state, state_next;
  logic [Count-1:0]      owner_grant, owner_grant_next;
  logic [IndexWidth-1:0] owner_index, owner_index_next;
  logic [IndexWidth-1:0] ptr, ptr_next;
  logic [HoldWidth-1:0]  hold, hold_next;

  logic [IndexWidth-1:0] pick_start;
  logic [Count-1:0]      pick_exclude;
  logic [Count-1:0]      pick_onehot;
  logic [IndexWidth-1:0] pick_index;
  logic                  pick_any;

  logic owner_requesting;
  logic others_requesting;
  logic keep_owner;
  logic take_new;

  function automatic logic [IndexWidth-1:0] wrap_inc(input logic [IndexWidth-1:0] i);
    return (i == LastIndex) ? '0 : i + IndexWidth'(1);
  endfunction

  // While owned, the search starts after the owner and never re-picks it;
  // this covers both the voluntary hand-off and the forced rotation.
  assign pick_start   = (state == OWNED) ? wrap_inc(owner_index) : ptr;
  assign pick_exclude = (state == OWNED) ? owner_grant : '0;

  rr_pick #(
    .Count(Count)
  ) u_pick (
    .request(request),
    .start  (pick_start),
    .exclude(pick_exclude),
    .pick   (pick_onehot),
    .index  (pick_index),
    .any    (pick_any)
  );

  assign owner_requesting  = |(request & owner_grant);
  assign others_requesting = |(request & ~owner_grant);
  assign keep_owner = owner_requesting &&
                      ((MaxHold == 0) || (hold < HoldLimit) || !others_requesting);
  assign take_new   = pick_any && ((state == IDLE) || !keep_owner);

  // State register: owner, pointer and hold counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      owner_grant <= '0;
      owner_index <= '0;
      ptr         <= '0;
      hold        <= '0;
    end else begin
      state       <= state_next;
      owner_grant <= owner_grant_next;
      owner_index <= owner_index_next;
      ptr         <= ptr_next;
      hold        <= hold_next;
    end
  end

  // Next-state: keep, hand off, force-rotate, or fall back to idle.
  always_comb begin
    state_next       = state;
    owner_grant_next = owner_grant;
    owner_index_next = owner_index;
    ptr_next         = ptr;
    hold_next        = hold;
    if (take_new) begin
      state_next       = OWNED;
      owner_grant_next = pick_onehot;
      owner_index_next = pick_index;
      ptr_next         = wrap_inc(pick_index);
      hold_next        = HoldWidth'(1);
    end else if (state == OWNED) begin
      if (keep_owner) begin
        if (hold < HoldLimit) begin
          hold_next = hold + HoldWidth'(1);
        end
      end else begin
        state_next       = IDLE;
        owner_grant_next = '0;
        owner_index_next = '0;
        hold_next        = '0;
      end
    end
  end

  // Outputs come straight from the registered owner state.
  always_comb begin
    grant       = owner_grant;
    grant_valid = (state == OWNED);
    grant_index = owner_index;
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter: hand-derived vector table, hand-written
// corner sequences, and a randomised phase against a behavioural model.
module tb_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset4, reset3;
  logic [3:0] request4;
  logic [2:0] request3;
  logic [3:0] grant4;
  logic       valid4;
  logic [1:0] index4;
  logic [2:0] grant3;
  logic       valid3;
  logic [1:0] index3;

  always #5 clk = ~clk;

  rr_arbiter #(.Count(4), .MaxHold(8)) dut4 (
    .clk        (clk),
    .reset      (reset4),
    .request    (request4),
    .grant      (grant4),
    .grant_valid(valid4),
    .grant_index(index4)
  );

  rr_arbiter #(.Count(3), .MaxHold(8)) dut3 (
    .clk        (clk),
    .reset      (reset3),
    .request    (request3),
    .grant      (grant3),
    .grant_valid(valid3),
    .grant_index(index3)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [3:0]  sb_q[$];
  int unsigned checks = 0;
  int unsigned passed = 0;

  // behavioural reference (Count=4, MaxHold=8) for the random phase
  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;

  function automatic void add(input logic rst, input logic [3:0] req, input logic [3:0] exp);
    vec_t v;
    v.rst = rst;
    v.req = req;
    v.exp = exp;
    vecs.push_back(v);
  endfunction

  function automatic logic [1:0] idx_of(input logic [3:0] g);
    logic [1:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction

  function automatic void m_take(input int c);
    m_owner = c;
    m_hold  = 1;
    m_ptr   = (c + 1) % 4;
  endfunction

  function automatic logic [3:0] model_step(input logic rst, input logic [3:0] req);
    logic [3:0] g;
    bit found;
    bit others;
    found = 1'b0;
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_hold  = 0;
    end else if (m_owner < 0) begin
      for (int i = 0; i < 4; i++) begin
        if (!found && req[(m_ptr + i) % 4]) begin
          m_take((m_ptr + i) % 4);
          found = 1'b1;
        end
      end
    end else begin
      others = 1'b0;
      for (int i = 0; i < 4; i++) if (i != m_owner && req[i]) others = 1'b1;
      if (req[m_owner] && (m_hold < 8 || !others)) begin
        if (m_hold < 8) m_hold++;
      end else begin
        for (int i = 1; i < 4; i++) begin
          if (!found && req[(m_owner + i) % 4]) begin
            m_take((m_owner + i) % 4);
            found = 1'b1;
          end
        end
        if (!found) begin
          m_owner = -1;
          m_hold  = 0;
        end
      end
    end
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  // Drive one cycle of stimulus, queue the expectation, compare after the edge.
  task automatic apply(input bit use3, input logic rst, input logic [3:0] req,
                       input logic [3:0] exp, input string tag);
    logic [3:0] e;
    @(negedge clk);
    if (use3) begin
      reset3   = rst;
      request3 = req[2:0];
    end else begin
      reset4   = rst;
      request4 = req;
    end
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    if (use3) begin
      check({tag, " grant"}, {1'b0, grant3}, e);
      check({tag, " valid"}, {3'b0, valid3}, {3'b0, |e});
      check({tag, " index"}, {2'b0, index3}, {2'b0, idx_of(e)});
    end else begin
      check({tag, " grant"}, grant4, e);
      check({tag, " valid"}, {3'b0, valid4}, {3'b0, |e});
      check({tag, " index"}, {2'b0, index4}, {2'b0, idx_of(e)});
    end
  endtask

  initial begin
    logic [3:0] rq;
    logic       rr;

    reset4   = 1'b1;
    reset3   = 1'b1;
    request4 = '0;
    request3 = '0;

    // reset then idle
    add(1'b1, 4'b0000, 4'b0000);
    for (int i = 0; i < 5; i++) add(1'b0, 4'b0000, 4'b0000);
    // all request; each owner drops for one cycle after two held cycles
    add(1'b0, 4'b1111, 4'b0001);
    add(1'b0, 4'b1111, 4'b0001);
    add(1'b0, 4'b1110, 4'b0010);
    add(1'b0, 4'b1111, 4'b0010);
    add(1'b0, 4'b1101, 4'b0100);
    add(1'b0, 4'b1111, 4'b0100);
    add(1'b0, 4'b1011, 4'b1000);
    add(1'b0, 4'b1111, 4'b1000);
    add(1'b0, 4'b0111, 4'b0001);
    add(1'b0, 4'b0000, 4'b0000);
    add(1'b0, 4'b0000, 4'b0000);
    // owner 1 vs requester 3: eight held cycles, then forced rotation
    for (int i = 0; i < 9; i++) add(1'b0, 4'b1010, (i < 8) ? 4'b0010 : 4'b1000);
    add(1'b0, 4'b0000, 4'b0000);
    add(1'b0, 4'b0110, 4'b0010);   // ptr must have wrapped to 0
    add(1'b0, 4'b0000, 4'b0000);
    // lone requester is never rotated away
    for (int i = 0; i < 20; i++) add(1'b0, 4'b0100, 4'b0100);
    add(1'b0, 4'b0000, 4'b0000);

    for (int i = 0; i < vecs.size(); i++)
      apply(1'b0, vecs[i].rst, vecs[i].req, vecs[i].exp, $sformatf("vec[%0d]", i));

    // reset while granted drops the grant; pointer returns to 0
    apply(1'b0, 1'b0, 4'b1000, 4'b1000, "rst_a");
    apply(1'b0, 1'b1, 4'b1000, 4'b0000, "rst_b");
    apply(1'b0, 1'b0, 4'b1000, 4'b1000, "rst_c");
    apply(1'b0, 1'b0, 4'b0010, 4'b0010, "rst_d");
    apply(1'b0, 1'b1, 4'b0010, 4'b0000, "rst_e");
    apply(1'b0, 1'b0, 4'b0110, 4'b0010, "rst_f");
    apply(1'b0, 1'b0, 4'b0000, 4'b0000, "rst_g");

    // Count=3: owner 2 drops, pointer wraps to 0
    apply(1'b1, 1'b1, 4'b0000, 4'b0000, "c3_rst");
    apply(1'b1, 1'b0, 4'b0111, 4'b0001, "c3_a");
    apply(1'b1, 1'b0, 4'b0111, 4'b0001, "c3_b");
    apply(1'b1, 1'b0, 4'b0110, 4'b0010, "c3_c");
    apply(1'b1, 1'b0, 4'b0111, 4'b0010, "c3_d");
    apply(1'b1, 1'b0, 4'b0101, 4'b0100, "c3_e");
    apply(1'b1, 1'b0, 4'b0011, 4'b0001, "c3_wrap");
    apply(1'b1, 1'b0, 4'b0000, 4'b0000, "c3_idle");

    // random phase with sticky requests so long holds occur
    rq = '0;
    apply(1'b0, 1'b1, rq, model_step(1'b1, rq), "rnd_rst");
    for (int n = 0; n < 300; n++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 7) == 0) rq[b] = ~rq[b];
      rr = ($urandom_range(0, 63) == 0);
      apply(1'b0, rr, rq, model_step(rr, rq), $sformatf("rnd[%0d]", n));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
